// File: rtl/mem_port_arbiter.sv
// Arbitrates N_MASTERS masters onto one single-port RAM (phase-select or round-robin),
// registers the RAM command and routes each read's data back to its issuer two cycles later.
module mem_port_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MODE      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [N_MASTERS-1:0]          wren_in,
    input  logic [N_MASTERS*DATA_W-1:0]   data_in,
    input  logic [N_MASTERS*ADDR_W-1:0]   addr_in,
    input  logic [$clog2(N_MASTERS)-1:0]  phase,
    input  logic [DATA_W-1:0]             q_mem,
    output logic [DATA_W-1:0]             data,
    output logic [ADDR_W-1:0]             address,
    output logic                          wren,
    output logic [N_MASTERS-1:0]          gnt,
    output logic [N_MASTERS-1:0]          rd_valid,
    output logic [DATA_W-1:0]             q_out
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    logic [IDX_W-1:0]     ptr_r;
    logic                 grant_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic [N_MASTERS-1:0] gnt_s;
    int                   cand_s;

    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic                 sel_wren_s;

    logic [ADDR_W-1:0]    address_r;
    logic [DATA_W-1:0]    data_r;
    logic                 wren_r;
    logic                 rd1_valid_r;
    logic [IDX_W-1:0]     rd1_idx_r;
    logic [N_MASTERS-1:0] rd_valid_r;
    logic [DATA_W-1:0]    q_out_r;

    function automatic logic [N_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_MASTERS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Grant selection: phase-indexed master, or first requester after the last winner.
    always_comb begin
        gnt_s       = '0;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        cand_s      = 32'sd0;
        if (reset) begin
            grant_s = 1'b0;
        end else if (MODE == 0) begin
            if (int'(phase) < N_MASTERS) begin
                grant_s     = req[phase];
                grant_idx_s = phase;
            end else begin
                grant_s = 1'b0;
            end
        end else begin
            // Searching offsets 1..N from ptr visits ptr itself last, so a lone
            // continuous requester still wins every cycle.
            for (int off = 1; off <= N_MASTERS; off++) begin
                cand_s = (int'(ptr_r) + off) % N_MASTERS;
                if (!grant_s && req[cand_s]) begin
                    grant_s     = 1'b1;
                    grant_idx_s = IDX_W'(cand_s);
                end else begin
                    grant_s = grant_s;
                end
            end
        end
        if (grant_s) begin
            gnt_s = idx_to_onehot(grant_idx_s);
        end else begin
            gnt_s = '0;
        end
    end

    // Command fields of the winning master.
    always_comb begin
        sel_addr_s = addr_in[grant_idx_s*ADDR_W +: ADDR_W];
        sel_data_s = data_in[grant_idx_s*DATA_W +: DATA_W];
        sel_wren_s = wren_in[grant_idx_s];
    end

    // RAM command register; idle cycles drop wren but keep address/data stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_r <= '0;
            data_r    <= '0;
            wren_r    <= 1'b0;
        end else if (grant_s) begin
            address_r <= sel_addr_s;
            data_r    <= sel_data_s;
            wren_r    <= sel_wren_s;
        end else begin
            wren_r    <= 1'b0;
        end
    end

    // Round-robin pointer tracks the most recent winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= LAST_IDX;
        end else if (grant_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Read-return pipeline: the issuer index travels with the read, so later
    // phase or grant changes cannot redirect it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_valid_r <= 1'b0;
            rd1_idx_r   <= '0;
            rd_valid_r  <= '0;
        end else begin
            rd1_valid_r <= grant_s & ~sel_wren_s;
            rd1_idx_r   <= grant_idx_s;
            if (rd1_valid_r) begin
                rd_valid_r <= idx_to_onehot(rd1_idx_r);
            end else begin
                rd_valid_r <= '0;
            end
        end
    end

    // Shared read-data register, loaded every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_out_r <= '0;
        end else begin
            q_out_r <= q_mem;
        end
    end

    assign gnt      = gnt_s;
    assign address  = address_r;
    assign data     = data_r;
    assign wren     = wren_r;
    assign rd_valid = rd_valid_r;
    assign q_out    = q_out_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: one phase-select and one round-robin arbiter, each with its own RAM, checked
// every cycle against a transaction-level model plus directed literal expectations.
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   wren_in = '0;
    logic [N*8-1:0] data_in = '0;
    logic [N*8-1:0] addr_in = '0;
    logic [1:0]     phase = '0;

    logic [7:0]   q_mem0, q_mem1, data0, data1, q_out0, q_out1, address0, address1;
    logic         wren0, wren1;
    logic [N-1:0] gnt0, gnt1, rd_valid0, rd_valid1;

    logic [7:0] ram0 [0:255];
    logic [7:0] ram1 [0:255];
    logic       ld_en = 1'b0;
    logic [7:0] ld_a = '0;
    logic [7:0] ld_d = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            ram0[ld_a] <= ld_d;
            ram1[ld_a] <= ld_d;
        end else begin
            if (wren0) ram0[address0] <= data0;
            if (wren1) ram1[address1] <= data1;
        end
    end
    assign q_mem0 = ram0[address0];
    assign q_mem1 = ram1[address1];

    mem_port_arbiter #(.N_MASTERS(N), .DATA_W(8), .ADDR_W(8), .MODE(0)) u_ph (
        .clk(clk), .reset(reset), .req(req), .wren_in(wren_in), .data_in(data_in),
        .addr_in(addr_in), .phase(phase), .q_mem(q_mem0), .data(data0), .address(address0),
        .wren(wren0), .gnt(gnt0), .rd_valid(rd_valid0), .q_out(q_out0));

    mem_port_arbiter #(.N_MASTERS(N), .DATA_W(8), .ADDR_W(8), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .req(req), .wren_in(wren_in), .data_in(data_in),
        .addr_in(addr_in), .phase(phase), .q_mem(q_mem1), .data(data1), .address(address1),
        .wren(wren1), .gnt(gnt1), .rd_valid(rd_valid1), .q_out(q_out1));

    // Model state: expected RAM command, pointer, memory image, outstanding reads.
    typedef struct {
        int         m;
        int         due;
        int         idx;
        logic [7:0] d;
    } rd_t;

    rd_t        pend[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         m_ptr[2];
    int         eg[2];
    logic [7:0] m_addr[2];
    logic [7:0] m_data[2];
    logic       m_wren[2];
    logic [7:0] exp_q[2];
    logic [7:0] mm[2][256];

    logic [31:0] s_gnt[2], s_rv[2], s_addr[2], s_data[2], s_wren[2], s_q[2];

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[u%0d] cycle %0d: actual=%0h expected=%0h", nm, m, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m]  = N - 1;
            m_addr[m] = 8'h00;
            m_data[m] = 8'h00;
            m_wren[m] = 1'b0;
            exp_q[m]  = 8'h00;
        end
        pend.delete();
    endtask

    // Index of the master that must win this cycle, or -1.
    function automatic int ref_grant(input int m);
        if (reset) return -1;
        if (m == 0) begin
            if (phase < 2'd3 && req[phase]) return int'(phase);
            return -1;
        end
        for (int off = 1; off <= N; off++) begin
            if (req[(m_ptr[1] + off) % N]) return (m_ptr[1] + off) % N;
        end
        return -1;
    endfunction

    task automatic sample();
        @(negedge clk);
        s_gnt[0]  = 32'(gnt0);      s_gnt[1]  = 32'(gnt1);
        s_rv[0]   = 32'(rd_valid0); s_rv[1]   = 32'(rd_valid1);
        s_addr[0] = 32'(address0);  s_addr[1] = 32'(address1);
        s_data[0] = 32'(data0);     s_data[1] = 32'(data1);
        s_wren[0] = 32'(wren0);     s_wren[1] = 32'(wren1);
        s_q[0]    = 32'(q_out0);    s_q[1]    = 32'(q_out1);
        if (reset) model_reset();
        for (int m = 0; m < 2; m++) begin
            logic [31:0] erv;
            int          hit;
            eg[m] = ref_grant(m);
            chk("gnt", m, s_gnt[m], (eg[m] < 0) ? 32'd0 : (32'd1 << eg[m]));
            chk("address", m, s_addr[m], 32'(m_addr[m]));
            chk("data", m, s_data[m], 32'(m_data[m]));
            chk("wren", m, s_wren[m], 32'(m_wren[m]));
            chk("q_out", m, s_q[m], 32'(exp_q[m]));
            erv = 32'd0;
            hit = -1;
            foreach (pend[i]) if (hit < 0 && pend[i].m == m && pend[i].due == cyc) hit = i;
            if (hit >= 0) begin
                erv = 32'd1 << pend[hit].idx;
                chk("read_data", m, s_q[m], 32'(pend[hit].d));
                pend.delete(hit);
            end
            chk("rd_valid", m, s_rv[m], erv);
        end
    endtask

    task automatic advance();
        if (reset) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                int         g;
                logic [7:0] a, d;
                g = eg[m];
                if (g >= 0) begin
                    a = addr_in[g*8 +: 8];
                    d = data_in[g*8 +: 8];
                    m_addr[m] = a;
                    m_data[m] = d;
                    m_wren[m] = wren_in[g];
                    m_ptr[m]  = g;
                    if (wren_in[g]) mm[m][a] = d;
                    else pend.push_back('{m, cyc + 2, g, mm[m][a]});
                end else begin
                    m_wren[m] = 1'b0;
                end
                exp_q[m] = (m == 0) ? q_mem0 : q_mem1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int seq_rr[6]  = '{1, 2, 4, 1, 2, 4};
    int rq37[6]    = '{5, 4, 4, 4, 0, 0};
    int gnt37[6]   = '{1, 4, 4, 4, 0, 0};
    int rv37[6]    = '{0, 0, 1, 4, 4, 4};

    initial begin
        // Preload both RAMs identically while held in reset.
        for (int a = 0; a < 256; a++) begin
            ld_a  = 8'(a);
            ld_d  = (a == 16) ? 8'hA7 : 8'($urandom);
            mm[0][a] = ld_d;
            mm[1][a] = ld_d;
            ld_en = 1'b1;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        model_reset();

        sample();
        chk("rst_address", 0, s_addr[0], 32'h00);
        chk("rst_wren", 1, s_wren[1], 32'h0);
        chk("rst_gnt", 1, s_gnt[1], 32'h0);
        advance();
        reset = 1'b0;

        // Round-robin with all three requesting.
        req = 3'b111; wren_in = 3'b000; phase = 2'd1;
        addr_in = {8'h30, 8'h2A, 8'h10};
        data_in = {8'h00, 8'h5C, 8'h00};
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("rr_seq", 1, s_gnt[1], 32'(seq_rr[i]));
            advance();
        end

        // Phase-select write, then an out-of-range phase.
        wren_in = 3'b010;
        sample();
        chk("ph_gnt", 0, s_gnt[0], 32'h2);
        advance();
        phase = 2'd3;
        sample();
        chk("ph3_gnt", 0, s_gnt[0], 32'h0);
        chk("wr_address", 0, s_addr[0], 32'h2A);
        chk("wr_data", 0, s_data[0], 32'h5C);
        chk("wr_wren", 0, s_wren[0], 32'h1);
        advance();
        sample();
        chk("ph3_wren", 0, s_wren[0], 32'h0);
        chk("ph3_hold_addr", 0, s_addr[0], 32'h2A);
        chk("ph3_hold_data", 0, s_data[0], 32'h5C);
        advance();

        // Phase-select read from master 0, then a write that must not return.
        req = 3'b001; wren_in = 3'b000; phase = 2'd0;
        sample();
        chk("rd_gnt", 0, s_gnt[0], 32'h1);
        advance();
        req = 3'b000;
        sample();
        chk("rd_early", 0, s_rv[0], 32'h0);
        advance();
        sample();
        chk("rd_ret", 0, s_rv[0], 32'h1);
        chk("rd_q", 0, s_q[0], 32'hA7);
        advance();
        req = 3'b001; wren_in = 3'b001; addr_in[7:0] = 8'h40; data_in[7:0] = 8'h11;
        sample();
        advance();
        req = 3'b000; wren_in = 3'b000;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("wr_no_rv", 0, s_rv[0], 32'h0);
            advance();
        end

        // Round-robin reads from masters 0 and 2 returning in order.
        reset = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        addr_in = {8'h50, 8'h2A, 8'h10};
        for (int i = 0; i < 6; i++) begin
            req = 3'(rq37[i]);
            sample();
            chk("rr37_gnt", 1, s_gnt[1], 32'(gnt37[i]));
            chk("rr37_rv", 1, s_rv[1], 32'(rv37[i]));
            advance();
        end

        // Reads in flight discarded by a reset arriving mid-cycle.
        req = 3'b011;
        sample();
        chk("fl_gnt0", 1, s_gnt[1], 32'h1);
        advance();
        sample();
        chk("fl_gnt1", 1, s_gnt[1], 32'h2);
        reset = 1'b1;
        advance();
        sample();
        advance();
        reset = 1'b0;
        req = 3'b000;
        sample();
        chk("post_addr", 1, s_addr[1], 32'h0);
        chk("post_data", 1, s_data[1], 32'h0);
        chk("post_q", 1, s_q[1], 32'h0);
        chk("post_rv", 1, s_rv[1], 32'h0);
        advance();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("post_rv", 1, s_rv[1], 32'h0);
            advance();
        end
        req = 3'b111;
        sample();
        chk("post_ptr", 1, s_gnt[1], 32'h1);
        advance();

        // Random traffic, including out-of-range phase values.
        for (int i = 0; i < 600; i++) begin
            req     = 3'($urandom);
            wren_in = 3'($urandom);
            data_in = 24'($urandom);
            addr_in = 24'($urandom);
            phase   = 2'($urandom_range(3, 0));
            sample();
            advance();
        end
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            sample();
            advance();
        end
        if (pend.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d reads never returned", pend.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
